wb_bot_hub: RTL
===============

# wb_bot_hub

Wishbone slave peripheral that lets the soft processor control and monitor up to eight Rojobot-style bot cores from a single register window. It holds a byte-lane-writable control register per bot and snapshots each bot's 32-bit info word when that bot signals an update. It keeps sticky per-bot pending flags with a mask, write-1-to-clear acknowledge and a saturating overrun counter, and drives one combined interrupt. All bot cores are assumed already synchronised to `clk`, so no clock-domain crossing happens in this block.

## Interface
- `NUM_BOTS`, default 2: number of bot channels, legal 1..8.
- `CTRL_W`, default 8: width of each bot control word, legal 8, 16, 24 or 32.
- `clk` in 1: system clock, 100 MHz; all logic is on the rising edge.
- `rstn` in 1: one clock; reset is asynchronous and active-low.
- `wb_adr_i` in 32: byte address. Only `[7:2]` is decoded; `[1:0]` is ignored.
- `wb_dat_i` in 32: write data.
- `wb_sel_i` in 4: byte-lane enables.
- `wb_we_i` in 1: write enable.
- `wb_cyc_i` in 1: bus cycle.
- `wb_stb_i` in 1: strobe.
- `wb_dat_o` out 32: read data, registered.
- `wb_ack_o` out 1: normal termination.
- `wb_err_o` out 1: error termination for unmapped addresses.
- `bot_info_i` in 32*NUM_BOTS: live info word per bot; bot n occupies `[32n+31:32n]`.
- `bot_upd_i` in NUM_BOTS: update strobe per bot, level or pulse.
- `bot_ctrl_o` out CTRL_W*NUM_BOTS: registered control word per bot.
- `irq_o` out 1: registered interrupt, equal to OR of (pending AND mask).

## Operation
- Register map, word aligned:
  - 0x00 STATUS, RO: `{0, pending[NUM_BOTS-1:0]}`.
  - 0x04 INT_ACK, WO: W1C on pending. Lane 0 only. Reads return 0.
  - 0x08 INT_MASK, RW: `mask[NUM_BOTS-1:0]`. Lane 0 only. Upper bits read 0.
  - 0x0C OVERRUN, RW: `{24'b0, ovr_cnt[7:0]}`. Any write with lane 0 set clears it to 0.
  - 0x10+8n INFO[n], RO: snapshot of bot n's info word.
  - 0x14+8n CTRL[n], RW: control word for bot n. Each byte updates only if its `wb_sel_i` lane is set and the byte lies below CTRL_W. Unused upper bits read 0.
- Any address in 0x10..0x4F with n ≥ NUM_BOTS, or any address ≥ 0x50, is unmapped. An unmapped access terminates with `wb_err_o` instead of `wb_ack_o`; writes have no effect and reads return 0.
- A write to an RO register is acked and ignored.
- Update detection: `upd_q` is `bot_upd_i` registered. A rise on bot n occurs when `bot_upd_i[n] & ~upd_q[n]`. On a rise:
  - INFO[n] takes `bot_info_i[n]` from that same cycle.
  - pending[n] is set.
- Overrun: a rise on bot n while pending[n] is already 1 and not being cleared in that cycle increments `ovr_cnt` by 1, saturating at 0xFF. Simultaneous rises on k bots that all qualify add k, still saturating.
- Pending priority: when a set and a W1C hit the same bit in the same cycle, the set wins and no overrun is counted.
- OVERRUN priority: a clear-write and an increment in the same cycle leave the count at the increment amount, counted from 0.
- `bot_ctrl_o` drives the CTRL registers directly.

## Timing
- Reset values: `wb_ack_o`=0, `wb_err_o`=0, `wb_dat_o`=0, `irq_o`=0, `bot_ctrl_o`=0, pending=0, mask=0, `ovr_cnt`=0, all INFO=0, `upd_q`=0.
- Reset asserted mid-transaction aborts it. No ack or err is issued for that cycle, and every register returns to its reset value.
- Bus handshake: a request is `wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o`.
  - Exactly one of ack/err asserts on the clock edge after the request and stays high for exactly 1 cycle.
  - Back-to-back requests therefore complete every 2 cycles.
  - The write takes effect on the same edge that asserts ack.
  - `wb_dat_o` is valid in the same cycle as ack.
- A read of STATUS or INFO returns the value held before the edge that asserts ack, so a same-cycle update is not visible to that read.
- `irq_o` lags any pending or mask change by 1 cycle.
- INFO capture happens on the edge that registers the rise, i.e. 1 cycle after `bot_upd_i` goes high.
- pending is visible in STATUS from the next read.
- `bot_upd_i` held high counts as one event. A new event requires a low cycle first.

## Test plan
- Reset, then read 0x00, 0x08, 0x0C, 0x14 -> all return 0. `irq_o`=0 and `bot_ctrl_o`=0.
- Write 0x14 with data 0xA5, sel 0x1; write 0x1C with data 0x3C, sel 0x0 -> `bot_ctrl_o[7:0]`=0xA5, `bot_ctrl_o[15:8]`=0x00. Each write is acked exactly 1 cycle after strobe.
- Set mask 0x3. Drive `bot_info_i[1]`=0xDEADBEEF and pulse `bot_upd_i[1]` -> INFO[1] at 0x18 reads 0xDEADBEEF, STATUS=0x2, and `irq_o` rises 2 cycles after the pulse. Write 0x2 to 0x04 -> STATUS=0 and `irq_o` falls 1 cycle after the ack.
- Pulse `bot_upd_i[0]` 300 times without acking -> OVERRUN reads 0xFF. Write 0x0C -> OVERRUN reads 0.
- Pulse `bot_upd_i[0]` in the same cycle the INT_ACK write of 0x1 commits -> STATUS=0x1 and OVERRUN unchanged.
- Read 0x20 and write 0x60 with NUM_BOTS=2 -> each is terminated by `wb_err_o` for 1 cycle with no ack, the read returns 0, and no register changes.

Source files
------------

// File: rtl/wb_bot_hub.sv
// wb_bot_hub
//   Wishbone slave that gives the soft processor one register window onto up
//   to eight bot cores. Holds a byte-writable control word per bot, snapshots
//   each bot's info word on an update edge, and keeps sticky pending flags
//   with a mask, write-1-to-clear acknowledge, a saturating overrun counter
//   and one combined registered interrupt.
//
// Ports
//   clk, rstn        : system clock, asynchronous active-low reset
//   wb_adr_i[31:0]   : byte address, only [7:2] decoded
//   wb_dat_i[31:0]   : write data
//   wb_sel_i[3:0]    : byte-lane enables
//   wb_we_i          : write enable
//   wb_cyc_i         : bus cycle
//   wb_stb_i         : strobe
//   wb_dat_o[31:0]   : registered read data, valid with ack/err
//   wb_ack_o         : normal termination (one cycle)
//   wb_err_o         : error termination for unmapped addresses (one cycle)
//   bot_info_i       : 32-bit live info word per bot, bot n at [32n+31:32n]
//   bot_upd_i        : update strobe per bot (level or pulse)
//   bot_ctrl_o       : CTRL_W-bit registered control word per bot
//   irq_o            : registered OR of (pending AND mask)
//
// Register map (word aligned)
//   0x00 STATUS  RO   pending flags
//   0x04 INT_ACK WO   write-1-to-clear pending (lane 0)
//   0x08 INT_MASK RW  interrupt mask (lane 0)
//   0x0C OVERRUN RW   saturating overrun count, lane-0 write clears
//   0x10+8n INFO[n] RO, 0x14+8n CTRL[n] RW
module wb_bot_hub #(
  parameter int NUM_BOTS = 2,
  parameter int CTRL_W   = 8
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [31:0]                  wb_adr_i,
  input  logic [31:0]                  wb_dat_i,
  input  logic [3:0]                   wb_sel_i,
  input  logic                         wb_we_i,
  input  logic                         wb_cyc_i,
  input  logic                         wb_stb_i,
  output logic [31:0]                  wb_dat_o,
  output logic                         wb_ack_o,
  output logic                         wb_err_o,
  input  logic [32*NUM_BOTS-1:0]       bot_info_i,
  input  logic [NUM_BOTS-1:0]          bot_upd_i,
  output logic [CTRL_W*NUM_BOTS-1:0]   bot_ctrl_o,
  output logic                         irq_o
);

  localparam int CTRL_BYTES = CTRL_W / 8;

  logic [5:0]          word;
  logic                req;
  logic                wr;
  logic                mapped;
  logic [31:0]         rd_data;

  logic [NUM_BOTS-1:0] pending;
  logic [NUM_BOTS-1:0] mask;
  logic [NUM_BOTS-1:0] upd_q;
  logic [NUM_BOTS-1:0] rise;
  logic [NUM_BOTS-1:0] clr;
  logic [NUM_BOTS-1:0] ovr_hit;

  logic [7:0]          ovr_cnt;
  logic [7:0]          ovr_base;
  logic [3:0]          ovr_inc;
  logic [8:0]          ovr_sum;
  logic [7:0]          ovr_next;

  logic [31:0]         info [NUM_BOTS];
  logic [CTRL_W-1:0]   ctrl [NUM_BOTS];

  // Address bits outside [7:2] and data/select bits beyond the implemented
  // register widths are deliberately ignored.
  logic                unused;
  assign unused = ^{wb_adr_i[31:8], wb_adr_i[1:0], wb_dat_i, wb_sel_i};

  assign word = wb_adr_i[7:2];
  // Masking with ack/err keeps a held strobe from issuing a second request
  // in the termination cycle, so each access completes in exactly two cycles.
  assign req  = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
  assign wr   = req & wb_we_i;

  assign rise    = bot_upd_i & ~upd_q;
  assign clr     = (wr && word == 6'd1 && wb_sel_i[0]) ? wb_dat_i[NUM_BOTS-1:0] : '0;
  // A rise only counts as an overrun when the flag would otherwise survive
  // this edge; a simultaneous acknowledge turns it into a fresh event.
  assign ovr_hit = rise & pending & ~clr;

  always_comb begin
    mapped  = (word < 6'd4);
    rd_data = '0;
    case (word)
      6'd0: rd_data[NUM_BOTS-1:0] = pending;
      6'd2: rd_data[NUM_BOTS-1:0] = mask;
      6'd3: rd_data[7:0]          = ovr_cnt;
      default: begin
        for (int i = 0; i < NUM_BOTS; i++) begin
          if (word == 6'(4 + 2 * i)) begin
            mapped  = 1'b1;
            rd_data = info[i];
          end
          if (word == 6'(5 + 2 * i)) begin
            mapped                = 1'b1;
            rd_data[CTRL_W-1:0]   = ctrl[i];
          end
        end
      end
    endcase
  end

  // A clear-write restarts the count from zero but still keeps the
  // increments that land on the same edge.
  always_comb begin
    ovr_inc = '0;
    for (int i = 0; i < NUM_BOTS; i++) begin
      ovr_inc = ovr_inc + 4'(ovr_hit[i]);
    end
    ovr_base = (wr && word == 6'd3 && wb_sel_i[0]) ? 8'd0 : ovr_cnt;
    ovr_sum  = {1'b0, ovr_base} + {5'b0, ovr_inc};
    ovr_next = ovr_sum[8] ? 8'hFF : ovr_sum[7:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= req & mapped;
      wb_err_o <= req & ~mapped;
      wb_dat_o <= req ? rd_data : '0;
    end
  end

  // Setting has priority over write-1-to-clear so no update is ever lost.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      upd_q   <= '0;
      pending <= '0;
      mask    <= '0;
      ovr_cnt <= '0;
      irq_o   <= 1'b0;
    end else begin
      upd_q   <= bot_upd_i;
      pending <= (pending & ~clr) | rise;
      ovr_cnt <= ovr_next;
      irq_o   <= |(pending & mask);
      if (wr && word == 6'd2 && wb_sel_i[0]) begin
        mask <= wb_dat_i[NUM_BOTS-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_BOTS; i++) begin
        info[i] <= '0;
        ctrl[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BOTS; i++) begin
        if (rise[i]) begin
          info[i] <= bot_info_i[32*i +: 32];
        end
        if (wr && word == 6'(5 + 2 * i)) begin
          for (int b = 0; b < CTRL_BYTES; b++) begin
            if (wb_sel_i[b]) begin
              ctrl[i][8*b +: 8] <= wb_dat_i[8*b +: 8];
            end
          end
        end
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_BOTS; g++) begin : g_ctrl
      assign bot_ctrl_o[g*CTRL_W +: CTRL_W] = ctrl[g];
    end
  endgenerate

endmodule
